// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared opcodes, pc_sel encodings and state enum
package pc_sequencer_pkg;

  localparam logic [5:0] OP_ALU    = 6'h00;
  localparam logic [5:0] OP_BRANCH = 6'h01;
  localparam logic [5:0] OP_JUMP   = 6'h02;
  localparam logic [5:0] OP_JR     = 6'h03;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_JMP = 2'd1;
  localparam logic [1:0] PCSEL_JR  = 2'd2;

  localparam logic [3:0] MAX_BRTYPE = 4'd8;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_HALT,
    ST_FAULT
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_ALU) || (op == OP_BRANCH) || (op == OP_JUMP) ||
           (op == OP_JR) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts consecutive stalled FETCH cycles
module fetch_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  // expired fires on the LIMIT-th stalled cycle, so the next edge leaves FETCH
  assign expired = enable && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/decode/exec/update control sequencer
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                imem_ready,
  input  logic [31:0]         instr,
  output logic                imem_req,
  output logic                ir_en,
  output logic                reg_we,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic [3:0]          brtype,
  output logic                halted,
  output logic                fault,
  output logic [RETIRE_W-1:0] retired
);

  state_t      state;
  state_t      next_state;
  logic [5:0]  op_q;
  logic [3:0]  bt_q;
  logic        tmo_clear;
  logic        tmo_enable;
  logic        tmo_expired;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^instr[21:0];

  // Held clear outside FETCH, so every entry into FETCH starts from zero
  assign tmo_clear  = reset || (state != ST_FETCH);
  assign tmo_enable = (state == ST_FETCH) && !imem_ready;

  fetch_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      op_q    <= '0;
      bt_q    <= '0;
      retired <= '0;
    end else begin
      state <= next_state;
      if (state == ST_FETCH && imem_ready) begin
        op_q <= instr[31:26];
        bt_q <= instr[25:22];
      end
      if (state == ST_UPDATE) begin
        retired <= retired + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    reg_we     = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = PCSEL_SEQ;
    brtype     = 4'd0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en      = 1'b1;
          next_state = ST_DECODE;
        end else if (tmo_expired) begin
          next_state = ST_FAULT;
        end
      end
      ST_DECODE: begin
        brtype = bt_q;
        if (!is_legal_op(op_q)) begin
          next_state = ST_FAULT;
        end else if (op_q == OP_HALT) begin
          next_state = ST_HALT;
        end else if (op_q == OP_BRANCH && bt_q > MAX_BRTYPE) begin
          next_state = ST_FAULT;
        end else begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        brtype     = bt_q;
        reg_we     = (op_q == OP_ALU);
        next_state = ST_UPDATE;
      end
      ST_UPDATE: begin
        brtype     = bt_q;
        pc_en      = 1'b1;
        next_state = ST_FETCH;
        if (op_q == OP_JUMP) begin
          pc_sel = PCSEL_JMP;
        end else if (op_q == OP_JR) begin
          pc_sel = PCSEL_JR;
        end
      end
      ST_HALT:  next_state = ST_HALT;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_FAULT;
    endcase
    // A reset cycle must never leak a side-effecting strobe
    if (reset) begin
      ir_en  = 1'b0;
      reg_we = 1'b0;
      pc_en  = 1'b0;
    end
  end

  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int TMO = 16;
  localparam int RW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_ready;
  logic [31:0]   instr;
  logic          imem_req;
  logic          ir_en;
  logic          reg_we;
  logic          pc_en;
  logic [1:0]    pc_sel;
  logic [3:0]    brtype;
  logic          halted;
  logic          fault;
  logic [RW-1:0] retired;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [RW-1:0] exp_ret;
  int            r;

  pc_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .RETIRE_W      (RW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_ready(imem_ready),
    .instr     (instr),
    .imem_req  (imem_req),
    .ir_en     (ir_en),
    .reg_we    (reg_we),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .brtype    (brtype),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'b0;
    instr      = $urandom;
    step();
    reset = 1'b0;
    #1;
    exp_ret = '0;
    chk("rst_imem_req", imem_req, 1);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_brtype", brtype, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retired", retired, exp_ret);
  endtask

  // Expected behaviour of one instruction: stall, accept, then outcome by class.
  // result: 0 retired, 1 halted, 2 faulted
  task automatic run_instr(input int waits, input logic [31:0] word, output int result);
    logic [5:0] op;
    logic [3:0] bt;
    logic [1:0] exp_sel;
    logic       known;
    op     = word[31:26];
    bt     = word[25:22];
    result = 0;
    for (int i = 0; i < waits && i < TMO; i++) begin
      imem_ready = 1'b0;
      instr      = $urandom;
      #1;
      chk("wait_imem_req", imem_req, 1);
      chk("wait_ir_en", ir_en, 0);
      chk("wait_fault", fault, 0);
      step();
    end
    if (waits >= TMO) begin
      for (int i = 0; i < 3; i++) begin
        imem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("tmo_fault", fault, 1);
        chk("tmo_imem_req", imem_req, 0);
        chk("tmo_ir_en", ir_en, 0);
        chk("tmo_pc_en", pc_en, 0);
        step();
      end
      result = 2;
      return;
    end
    imem_ready = 1'b1;
    instr      = word;
    #1;
    chk("acc_imem_req", imem_req, 1);
    chk("acc_ir_en", ir_en, 1);
    chk("acc_pc_en", pc_en, 0);
    step();
    imem_ready = 1'($urandom_range(0, 1));
    instr      = $urandom;
    #1;
    chk("dec_brtype", brtype, bt);
    chk("dec_ir_en", ir_en, 0);
    chk("dec_imem_req", imem_req, 0);
    chk("dec_reg_we", reg_we, 0);
    chk("dec_pc_en", pc_en, 0);
    step();
    known = (op == 6'h00) || (op == 6'h01) || (op == 6'h02) || (op == 6'h03) || (op == 6'h3F);
    if (!known || (op == 6'h01 && bt > 4'd8)) begin
      for (int i = 0; i < 3; i++) begin
        imem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("bad_fault", fault, 1);
        chk("bad_halted", halted, 0);
        chk("bad_pc_en", pc_en, 0);
        chk("bad_imem_req", imem_req, 0);
        chk("bad_brtype", brtype, 0);
        step();
      end
      result = 2;
      return;
    end
    if (op == 6'h3F) begin
      for (int i = 0; i < 3; i++) begin
        imem_ready = 1'($urandom_range(0, 1));
        #1;
        chk("halt_halted", halted, 1);
        chk("halt_fault", fault, 0);
        chk("halt_retired", retired, exp_ret);
        chk("halt_imem_req", imem_req, 0);
        chk("halt_pc_en", pc_en, 0);
        step();
      end
      result = 1;
      return;
    end
    imem_ready = 1'($urandom_range(0, 1));
    #1;
    chk("exe_reg_we", reg_we, (op == 6'h00) ? 1 : 0);
    chk("exe_pc_en", pc_en, 0);
    chk("exe_brtype", brtype, bt);
    step();
    exp_sel = (op == 6'h02) ? 2'd1 : (op == 6'h03) ? 2'd2 : 2'd0;
    #1;
    chk("upd_pc_en", pc_en, 1);
    chk("upd_pc_sel", pc_sel, exp_sel);
    chk("upd_reg_we", reg_we, 0);
    chk("upd_brtype", brtype, bt);
    chk("upd_imem_req", imem_req, 0);
    step();
    exp_ret    = exp_ret + 1'b1;
    imem_ready = 1'b0;
    #1;
    chk("post_retired", retired, exp_ret);
    chk("post_pc_en", pc_en, 0);
    chk("post_pc_sel", pc_sel, 0);
    chk("post_brtype", brtype, 0);
    chk("post_imem_req", imem_req, 1);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] word;
    int          k;
    int          waits;
    reset      = 1'b1;
    imem_ready = 1'b0;
    instr      = '0;
    exp_ret    = '0;
    step();
    do_reset();

    run_instr(0, 32'h0000_0000, r);
    chk("alu_res", r, 0);
    run_instr(0, 32'h0880_0000, r);
    chk("jump_res", r, 0);
    run_instr(0, 32'h0C00_0000, r);
    chk("jr_res", r, 0);
    run_instr(0, 32'h0440_0010, r);
    chk("br1_res", r, 0);
    run_instr(15, 32'h0000_0000, r);
    chk("wait15_res", r, 0);
    run_instr(16, 32'h0000_0000, r);
    chk("wait16_res", r, 2);
    do_reset();
    run_instr(0, 32'h0640_0000, r);
    chk("br9_res", r, 2);
    do_reset();
    run_instr(0, 32'h0000_0000, r);
    run_instr(0, 32'hFC00_0000, r);
    chk("halt_res", r, 1);
    do_reset();

    // Reset landing on an UPDATE cycle
    run_instr(0, 32'h0000_0000, r);
    imem_ready = 1'b1;
    instr      = 32'h0000_0000;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rstupd_pc_en", pc_en, 0);
    chk("rstupd_reg_we", reg_we, 0);
    step();
    reset      = 1'b0;
    imem_ready = 1'b0;
    exp_ret    = '0;
    #1;
    chk("rstupd_retired", retired, 0);
    chk("rstupd_imem_req", imem_req, 1);

    // Enough back-to-back retires to wrap the narrow counter
    for (int i = 0; i < 18; i++) begin
      run_instr(0, {6'h00, 26'($urandom)}, r);
    end

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 19);
      if (k <= 5)       op = 6'h00;
      else if (k <= 10) op = 6'h01;
      else if (k <= 13) op = 6'h02;
      else if (k <= 16) op = 6'h03;
      else if (k == 17) op = 6'h3F;
      else              op = 6'($urandom);
      word  = {op, 26'($urandom)};
      waits = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 17) : $urandom_range(0, 2);
      run_instr(waits, word, r);
      if (r != 0) begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum FETCH cycles allowed with imem_ready low.
REQ-002 Parameter RETIRE_W, default 32: width of retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 imem_ready  input  1  instruction memory ack; instr valid when high.
REQ-006 instr  input  32  fetched instruction word.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 ir_en  output  1  instruction-register load strobe.
REQ-009 reg_we  output  1  register-file write enable.
REQ-010 pc_en  output  1  PC update strobe to next-address logic.
REQ-011 pc_sel  output  2  next-PC source: 0 sequential/branch, 1 jump label, 2 jump register.
REQ-012 brtype  output  4  branch condition select, from instr[25:22].
REQ-013 halted  output  1  high while in HALT.
REQ-014 fault  output  1  high while in FAULT.
REQ-015 retired  output  RETIRE_W  count of completed PC updates.

Function
REQ-016 opcode = instr[31:26]; classes: 6'h00 ALU, 6'h01 BRANCH, 6'h02 JUMP, 6'h03 JR, 6'h3F HALT; all others illegal.
REQ-017 States: FETCH, DECODE, EXEC, UPDATE, HALT, FAULT; Moore outputs from state plus latched opcode/brtype.
REQ-018 FETCH: imem_req=1; imem_ready high -> ir_en=1 same cycle, latch opcode and instr[25:22], go DECODE; else stay, increment wait counter.
REQ-019 Wait counter clears on entering FETCH; TIMEOUT_CYCLES consecutive FETCH cycles with imem_ready low -> FAULT; ready high on cycle TIMEOUT_CYCLES is too late.
REQ-020 DECODE: one cycle; illegal opcode -> FAULT; BRANCH with brtype > 8 -> FAULT; HALT -> HALT; else EXEC.
REQ-021 EXEC: one cycle; reg_we=1 only for ALU; go UPDATE.
REQ-022 UPDATE: pc_en=1 for exactly one cycle; pc_sel=0 for ALU/BRANCH, 1 JUMP, 2 JR; retired increments; go FETCH.
REQ-023 brtype output holds latched field from DECODE through UPDATE; 0 otherwise.
REQ-024 pc_sel never drives 3; pc_sel=0 outside UPDATE.
REQ-025 Nominal latency: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXEC, UPDATE).
REQ-026 imem_ready outside FETCH ignored; instr sampled only on FETCH accept cycle.
REQ-027 retired wraps from 2^RETIRE_W-1 to 0 without flag.
REQ-028 HALT and FAULT are terminal; exit only via reset; imem_req, pc_en, reg_we, ir_en all 0 there.

Reset
REQ-029 reset high at posedge: state FETCH, wait counter 0, retired 0, latched fields 0, all outputs 0 except imem_req=1 in first cycle after reset.
REQ-030 Reset has priority over every transition, including mid-FETCH wait, UPDATE, HALT, FAULT; no pc_en or reg_we pulse issued in a reset cycle.

Structure
REQ-031 Shared package holds opcode constants, pc_sel encodings (PCSEL_SEQ/JMP/JR), max legal brtype (8), state enum.
REQ-032 One sub-module: fetch_timeout_counter (clear, enable, expired) instantiated in pc_sequencer.

Verification
REQ-033 Reset, instr=0x0000_0000 (ALU), ready always high -> ir_en cycle 1, reg_we cycle 3, pc_en with pc_sel=0 cycle 4, retired=1.
REQ-034 instr=0x0880_0000 (JUMP), ready high -> pc_en with pc_sel=1 on UPDATE, reg_we never asserted.
REQ-035 instr=0x0440_0010 (BRANCH, brtype=1) -> brtype=1 DECODE..UPDATE, pc_sel=0; instr with brtype=9 -> fault=1 after DECODE, pc_en never high.
REQ-036 ready low 15 cycles then high -> accepted, normal flow; ready low 16 cycles -> fault=1, imem_req=0 thereafter.
REQ-037 instr=0xFC00_0000 -> halted=1 after DECODE, retired unchanged; reset asserted -> FETCH, halted=0, retired=0.
REQ-038 reset asserted during UPDATE -> no pc_en that cycle, retired=0 next cycle.
